// File: rtl/delay_sched_pkg.sv
// rtl/delay_sched_pkg.sv - shared constants and helpers for the delay channel scheduler
package delay_sched_pkg;

    localparam int N_CH = 4;

    localparam logic [2:0] OP_START   = 3'd0;
    localparam logic [2:0] OP_STOP    = 3'd1;
    localparam logic [2:0] OP_READ    = 3'd2;
    localparam logic [2:0] OP_STATUS  = 3'd3;
    localparam logic [2:0] OP_CLEAR   = 3'd4;
    localparam logic [2:0] OP_WAIT    = 3'd5;
    localparam logic [2:0] OP_IRQMASK = 3'd6;
    localparam logic [2:0] OP_RSVD    = 3'd7;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_WAITING = 1'b1
    } sched_state_t;

    localparam int ST_RUN_LSB = 0;
    localparam int ST_EXP_LSB = 4;
    localparam int ST_MSK_LSB = 8;

    function automatic logic [31:0] pack_status(input logic [3:0] mask,
                                                input logic [3:0] expired,
                                                input logic [3:0] running);
        return (32'(mask) << ST_MSK_LSB) | (32'(expired) << ST_EXP_LSB) |
               (32'(running) << ST_RUN_LSB);
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - free-running microsecond prescaler producing a one-cycle tick
module us_tick_gen #(
    parameter int unsigned clockFrequencyInHz = 50000000
) (
    input  logic clock,
    input  logic resetN,
    output logic tick
);

    localparam int unsigned R = clockFrequencyInHz / 1000000;
    localparam int W = $clog2(R);

    logic [W-1:0] r_presc;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_presc <= W'(R - 1);
        end else if (r_presc == '0) begin
            r_presc <= W'(R - 1);
        end else begin
            r_presc <= r_presc - 1'b1;
        end
    end

    assign tick = (r_presc == '0);

endmodule

// File: rtl/delay_channel_scheduler.sv
// rtl/delay_channel_scheduler.sv - four countdown channels behind a custom-instruction port
module delay_channel_scheduler
    import delay_sched_pkg::*;
#(
    parameter int unsigned clockFrequencyInHz  = 50000000,
    parameter logic [7:0]  customInstructionId = 8'd0
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic        ciDone,
    output logic [31:0] ciResult,
    output logic        irq
);

    logic            w_tick;
    logic            w_accept;
    logic [2:0]      w_op;
    logic [1:0]      w_ch;
    logic [31:0]     w_a;
    logic [N_CH-1:0] w_exp_evt;
    logic            w_wait_end;
    logic            w_unused;

    sched_state_t    r_state;
    logic [1:0]      r_wait_ch;
    logic [31:0]     r_count [N_CH];
    logic [N_CH-1:0] r_running;
    logic [N_CH-1:0] r_expired;
    logic [3:0]      r_irq_mask;
    logic            r_done;
    logic [31:0]     r_result;
    logic            r_irq;

    us_tick_gen #(
        .clockFrequencyInHz(clockFrequencyInHz)
    ) u_tick (
        .clock (clock),
        .resetN(resetN),
        .tick  (w_tick)
    );

    assign w_op       = ciValueB[2:0];
    assign w_ch       = ciValueB[5:4];
    assign w_a        = ciValueA;
    assign w_accept   = ciStart & ciCke & (ciN == customInstructionId) & (r_state == S_IDLE);
    assign w_wait_end = (r_state == S_WAITING) & ~r_running[r_wait_ch];
    assign w_unused   = ^{ciValueB[31:6], ciValueB[3]};

    always_comb begin
        w_exp_evt = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_exp_evt[i] = r_running[i] & w_tick & (r_count[i] == 32'd1);
        end
    end

    // Later assignments override earlier ones: commands beat the tick, expiry beats clears.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < N_CH; i++) begin
                r_count[i] <= '0;
            end
            r_running <= '0;
            r_expired <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (r_running[i] && w_tick && (r_count[i] != '0)) begin
                    r_count[i] <= r_count[i] - 32'd1;
                end
                if (w_exp_evt[i]) begin
                    r_running[i] <= 1'b0;
                    r_expired[i] <= 1'b1;
                end
                if (w_accept && (w_ch == 2'(i))) begin
                    if (w_op == OP_START) begin
                        r_count[i]   <= w_a;
                        r_running[i] <= (w_a != '0);
                        r_expired[i] <= r_expired[i] | (w_a == '0);
                    end else if (w_op == OP_STOP) begin
                        r_count[i]   <= '0;
                        r_running[i] <= 1'b0;
                        r_expired[i] <= r_expired[i];
                    end
                end
                if (w_accept && (w_op == OP_CLEAR) && w_a[i] && !w_exp_evt[i]) begin
                    r_expired[i] <= 1'b0;
                end
                if (w_wait_end && (r_wait_ch == 2'(i)) && !w_exp_evt[i]) begin
                    r_expired[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state    <= S_IDLE;
            r_wait_ch  <= '0;
            r_irq_mask <= '0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_result <= '0;
            r_irq    <= |(r_expired & r_irq_mask);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_done <= 1'b1;
                        case (w_op)
                            OP_STOP, OP_READ: r_result <= r_count[w_ch];
                            OP_STATUS:        r_result <= pack_status(r_irq_mask, r_expired, r_running);
                            OP_CLEAR:         r_result <= {28'd0, r_expired};
                            OP_WAIT: begin
                                if (r_running[w_ch]) begin
                                    r_done    <= 1'b0;
                                    r_state   <= S_WAITING;
                                    r_wait_ch <= w_ch;
                                end
                            end
                            OP_IRQMASK: begin
                                r_result   <= {28'd0, r_irq_mask};
                                r_irq_mask <= w_a[3:0];
                            end
                            default: r_result <= '0;
                        endcase
                    end
                end
                S_WAITING: begin
                    if (w_wait_end) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ciDone   = r_done;
    assign ciResult = r_result;
    assign irq      = r_irq;

endmodule

// File: tb/tb_delay_channel_scheduler.sv
// tb/tb_delay_channel_scheduler.sv - directed self-checking bench with a cycle-level behavioural model
module tb_delay_channel_scheduler;
    import delay_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ciStart, ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA, ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;
    logic        irq;

    int n_asserts = 0;
    int n_fail    = 0;

    delay_channel_scheduler #(
        .clockFrequencyInHz (50000000),
        .customInstructionId(8'd0)
    ) dut (
        .clock   (clk),
        .resetN  (rst_n),
        .ciStart (ciStart),
        .ciCke   (ciCke),
        .ciN     (ciN),
        .ciValueA(ciValueA),
        .ciValueB(ciValueB),
        .ciDone  (ciDone),
        .ciResult(ciResult),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Model: a tick happens in every cycle whose index since reset release is 49 mod 50.
    int          cyc;
    logic [31:0] m_cnt [4];
    logic [3:0]  m_run, m_exp, m_mask;
    bit          m_wait;
    int          m_wch;
    logic        e_done;
    logic [31:0] e_res;
    logic        e_irq;

    task automatic reset_model();
        cyc = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_run = 0; m_exp = 0; m_mask = 0; m_wait = 0; m_wch = 0;
        e_done = 0; e_res = 0; e_irq = 0;
    endtask

    task automatic step_model();
        bit          tick;
        bit          acc;
        int          op, ch;
        logic [31:0] a;
        logic [31:0] n_cnt [4];
        logic [3:0]  n_run, n_exp, n_mask, evt;
        tick = (cyc % 50) == 49;
        cyc++;
        acc = ciStart && ciCke && (ciN == 8'd0) && !m_wait;
        op = int'(ciValueB[2:0]);
        ch = int'(ciValueB[5:4]);
        a  = ciValueA;
        n_run = m_run; n_exp = m_exp; n_mask = m_mask; evt = 0;
        for (int i = 0; i < 4; i++) begin
            n_cnt[i] = m_cnt[i];
            if (m_run[i] && tick) begin
                n_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 1) begin
                    evt[i] = 1; n_run[i] = 0; n_exp[i] = 1;
                end
            end
        end
        e_irq = |(m_exp & m_mask);
        e_done = 0; e_res = 0;
        if (m_wait) begin
            if (!m_run[m_wch]) begin
                e_done = 1; m_wait = 0;
                if (!evt[m_wch]) n_exp[m_wch] = 0;
            end
        end else if (acc) begin
            e_done = 1;
            case (op)
                0: begin n_cnt[ch] = a; n_run[ch] = (a != 0); n_exp[ch] = m_exp[ch] | (a == 0); end
                1: begin e_res = m_cnt[ch]; n_cnt[ch] = 0; n_run[ch] = 0; n_exp[ch] = m_exp[ch]; end
                2: e_res = m_cnt[ch];
                3: e_res = {20'd0, m_mask, m_exp, m_run};
                4: begin e_res = {28'd0, m_exp}; n_exp = (m_exp & ~a[3:0]) | evt; end
                5: if (m_run[ch]) begin e_done = 0; m_wait = 1; m_wch = ch; end
                6: begin e_res = {28'd0, m_mask}; n_mask = a[3:0]; end
                default: e_res = 0;
            endcase
        end
        for (int i = 0; i < 4; i++) m_cnt[i] = n_cnt[i];
        m_run = n_run; m_exp = n_exp; m_mask = n_mask;
    endtask

    initial begin
        reset_model();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) reset_model();
            else step_model();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_true(input string nm, input bit ok, input int act, input string req);
        n_asserts++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %s", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        chk("model_ciDone", 32'(ciDone), 32'(e_done));
        chk("model_ciResult", ciResult, e_res);
        chk("model_irq", 32'(irq), 32'(e_irq));
    end

    task automatic ci(input logic [2:0] op, input logic [1:0] ch, input logic [31:0] a,
                      input int budget, output logic [31:0] res, output int lat);
        ciStart = 1; ciCke = 1; ciN = 8'd0; ciValueA = a; ciValueB = {26'd0, ch, 1'b0, op};
        @(negedge clk);
        ciStart = 0; ciCke = 0; ciValueA = 0; ciValueB = 0;
        lat = 1; res = 0;
        while (!ciDone && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        n_asserts++;
        if (ciDone) res = ciResult;
        else begin
            n_fail++;
            $display("FAIL ci_timeout op=%0d: no ciDone within %0d cycles", op, budget);
        end
    endtask

    task automatic wait_tick_cycle();
        for (int k = 0; k < 60; k++) begin
            if ((cyc % 50) == 49) break;
            @(negedge clk);
        end
    endtask

    logic [31:0] res, rd;
    int          lat, seen;

    initial begin
        rst_n = 0; ciStart = 0; ciCke = 0; ciN = 0; ciValueA = 0; ciValueB = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Reset while counting, then check the tick phase restarts from release.
        ci(OP_START, 2'd0, 32'd100, 5, res, lat);
        repeat (20) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_ciDone", 32'(ciDone), 32'd0);
        chk("rst_ciResult", ciResult, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        ci(OP_STATUS, 2'd0, 32'd0, 5, res, lat);
        chk("rst_status", res, 32'd0);
        chk("status_latency", 32'(lat), 32'd1);
        ci(OP_START, 2'd0, 32'd1, 5, res, lat);
        ci(OP_WAIT, 2'd0, 32'd0, 200, res, lat);
        chk("first_tick_wait_latency", 32'(lat), 32'd49);
        chk("first_wait_result", res, 32'd0);

        // START ch2 A=3 then blocking WAIT.
        ci(OP_START, 2'd2, 32'd3, 5, res, lat);
        chk("start_result", res, 32'd0);
        ci(OP_WAIT, 2'd2, 32'd0, 400, res, lat);
        chk_true("wait3_latency", lat >= 101 && lat <= 151, lat, "101..151");
        chk("wait3_result", res, 32'd0);
        ci(OP_STATUS, 2'd0, 32'd0, 5, res, lat);
        chk("wait3_exp2_cleared", res & 32'h44, 32'd0);

        // READ then STOP 250 cycles (five ticks) later.
        ci(OP_START, 2'd0, 32'd10, 5, res, lat);
        ci(OP_READ, 2'd0, 32'd0, 5, rd, lat);
        chk_true("read_10_or_9", rd == 10 || rd == 9, int'(rd), "9 or 10");
        repeat (249) @(negedge clk);
        ci(OP_STOP, 2'd0, 32'd0, 5, res, lat);
        chk("stop_remaining", res, 32'd5);
        ci(OP_STATUS, 2'd0, 32'd0, 5, res, lat);
        chk("stop_running0", res & 32'h1, 32'd0);

        // Interrupt path.
        ci(OP_IRQMASK, 2'd0, 32'd1, 5, res, lat);
        chk("irqmask_prev", res, 32'd0);
        ci(OP_START, 2'd0, 32'd1, 5, res, lat);
        lat = 1;
        while (!irq && lat < 52) begin
            @(negedge clk);
            lat++;
        end
        chk_true("irq_within_52", irq == 1'b1, lat, "irq=1 by cycle 52");
        ci(OP_CLEAR, 2'd0, 32'd1, 5, res, lat);
        chk("clear_prev_expired", res, 32'h1);
        chk("irq_still_high", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq_dropped", 32'(irq), 32'd0);

        // Zero count and wait on an idle channel.
        ci(OP_START, 2'd1, 32'd0, 5, res, lat);
        chk("start0_latency", 32'(lat), 32'd1);
        ci(OP_STATUS, 2'd0, 32'd0, 5, res, lat);
        chk("start0_expired1", res & 32'h22, 32'h20);
        ci(OP_WAIT, 2'd3, 32'd0, 5, res, lat);
        chk("wait_idle_latency", 32'(lat), 32'd1);
        chk("wait_idle_result", res, 32'd0);
        ci(OP_RSVD, 2'd0, 32'hFFFF_FFFF, 5, res, lat);
        chk("reserved_result", res, 32'd0);

        // START landing on the expiry tick wins.
        ci(OP_CLEAR, 2'd0, 32'h2, 5, res, lat);
        chk("clear1_prev", res, 32'h2);
        ci(OP_START, 2'd1, 32'd1, 5, res, lat);
        wait_tick_cycle();
        ci(OP_START, 2'd1, 32'd7, 5, res, lat);
        ci(OP_READ, 2'd1, 32'd0, 5, res, lat);
        chk("collide_count7", res, 32'd7);
        ci(OP_STATUS, 2'd0, 32'd0, 5, res, lat);
        chk("collide_run1_exp1", res & 32'h22, 32'h02);

        // STOP landing on the expiry tick wins.
        ci(OP_START, 2'd3, 32'd1, 5, res, lat);
        wait_tick_cycle();
        ci(OP_STOP, 2'd3, 32'd0, 5, res, lat);
        chk("stop_collide_result", res, 32'd1);
        ci(OP_STATUS, 2'd0, 32'd0, 5, res, lat);
        chk("stop_collide_ch3", res & 32'h88, 32'd0);

        // Strobes that must not be accepted.
        ciStart = 1; ciCke = 1; ciN = 8'h05; ciValueB = {29'd0, OP_STATUS};
        @(negedge clk);
        ciCke = 0; ciN = 8'h00;
        @(negedge clk);
        ciStart = 0; ciValueB = 0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (ciDone) seen++;
            @(negedge clk);
        end
        chk("rejected_strobe_no_done", 32'(seen), 32'd0);

        // Reset in the middle of a blocking WAIT.
        ci(OP_START, 2'd2, 32'd5, 5, res, lat);
        ciStart = 1; ciCke = 1; ciN = 0; ciValueB = {26'd0, 2'd2, 1'b0, OP_WAIT};
        @(negedge clk);
        ciStart = 0; ciCke = 0; ciValueB = 0;
        repeat (30) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_ciDone", 32'(ciDone), 32'd0);
        chk("abort_irq", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ciDone) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        ci(OP_STATUS, 2'd0, 32'd0, 5, res, lat);
        chk("abort_status", res, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 20000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
